multimode_sweep: RTL

Parametrised successor to the triangle sweep generator. It adds selectable waveform mode (triangle, sawtooth up, sawtooth down, triggered single-shot), hold, turn-around and done flags, and a sweep counter. It sits in the servo setpoint/modulation path and feeds a DAC or summing stage. Accumulator precision and output width are generics.

---
 rtl/multimode_sweep.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/multimode_sweep.sv
// Multi-mode sweep generator: triangle, sawtooth up/down and triggered single-shot ramps
// between signed bounds, with hold, turn/done flags and a sweep counter.
module multimode_sweep #(
  parameter int SIGNAL_OUT_SIZE = 16,
  parameter int ACC_FRAC        = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       on_in,
  input  logic [1:0]                 mode_in,
  input  logic                       hold_in,
  input  logic                       trig_in,
  input  logic [15:0]                minval_in,
  input  logic [15:0]                maxval_in,
  input  logic [31:0]                stepsize_in,
  output logic [SIGNAL_OUT_SIZE+1:0] signal_out,
  output logic                       dir_out,
  output logic                       turn_out,
  output logic                       done_out,
  output logic [15:0]                sweep_count_out
);

  localparam int AccW = 18 + ACC_FRAC;
  localparam int ExtW = AccW + 1;

  typedef enum logic [1:0] {StArmed, StRun, StDone} shot_e;

  logic [AccW-1:0] acc_q, acc_d;
  logic            dir_q, dir_d;
  logic            done_q, done_d;
  logic            turn_q, turn_d;
  logic [15:0]     cnt_q, cnt_d;
  shot_e           st_q, st_d;
  logic            active_q;
  logic [1:0]      mode_q;

  logic signed [ExtW-1:0] acc_x, step_x, min_x, max_x, up_x, dn_x;
  logic                   misconfig, step_zero, restart;

  // Bounds and accumulator widened by one bit so +/- step can never overflow.
  assign acc_x     = $signed({acc_q[AccW-1], acc_q});
  assign step_x    = $signed({{(ExtW-32){1'b0}}, stepsize_in});
  assign min_x     = $signed({{3{minval_in[15]}}, minval_in, {ACC_FRAC{1'b0}}});
  assign max_x     = $signed({{3{maxval_in[15]}}, maxval_in, {ACC_FRAC{1'b0}}});
  assign up_x      = acc_x + step_x;
  assign dn_x      = acc_x - step_x;
  assign misconfig = $signed(minval_in) > $signed(maxval_in);
  assign step_zero = (stepsize_in == 32'd0);
  assign restart   = !active_q || (mode_in != mode_q);

  always_comb begin
    acc_d  = acc_q;
    dir_d  = dir_q;
    done_d = done_q;
    cnt_d  = cnt_q;
    st_d   = st_q;
    turn_d = 1'b0;
    if (!on_in) begin
      acc_d  = '0;
      dir_d  = 1'b0;
      done_d = 1'b0;
      cnt_d  = '0;
      st_d   = StArmed;
    end else if (restart) begin
      acc_d  = (mode_in == 2'd2) ? max_x[AccW-1:0] : min_x[AccW-1:0];
      dir_d  = (mode_in == 2'd2);
      done_d = 1'b0;
      cnt_d  = '0;
      st_d   = StArmed;
    end else if (hold_in) begin
      acc_d = acc_q;
    end else if (misconfig) begin
      acc_d = min_x[AccW-1:0];
    end else begin
      unique case (mode_in)
        2'd0: begin
          if (!step_zero) begin
            if (!dir_q) begin
              if (up_x >= max_x) begin
                acc_d  = max_x[AccW-1:0];
                dir_d  = 1'b1;
                turn_d = 1'b1;
              end else begin
                acc_d = up_x[AccW-1:0];
              end
            end else if (dn_x <= min_x) begin
              acc_d  = min_x[AccW-1:0];
              dir_d  = 1'b0;
              turn_d = 1'b1;
            end else begin
              acc_d = dn_x[AccW-1:0];
            end
          end
        end
        2'd1: begin
          if (!step_zero) begin
            if (up_x > max_x) begin
              acc_d  = min_x[AccW-1:0];
              turn_d = 1'b1;
            end else begin
              acc_d = up_x[AccW-1:0];
            end
          end
        end
        2'd2: begin
          if (!step_zero) begin
            if (dn_x < min_x) begin
              acc_d  = max_x[AccW-1:0];
              turn_d = 1'b1;
            end else begin
              acc_d = dn_x[AccW-1:0];
            end
          end
        end
        2'd3: begin
          if (st_q == StRun) begin
            if (!step_zero) begin
              if (up_x >= max_x) begin
                acc_d  = max_x[AccW-1:0];
                turn_d = 1'b1;
                done_d = 1'b1;
                st_d   = StDone;
              end else begin
                acc_d = up_x[AccW-1:0];
              end
            end
          end else if (trig_in) begin
            acc_d  = min_x[AccW-1:0];
            done_d = 1'b0;
            st_d   = StRun;
          end
        end
      endcase
      if (turn_d) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_q    <= '0;
      dir_q    <= 1'b0;
      done_q   <= 1'b0;
      turn_q   <= 1'b0;
      cnt_q    <= '0;
      st_q     <= StArmed;
      active_q <= 1'b0;
      mode_q   <= 2'd0;
    end else begin
      acc_q    <= acc_d;
      dir_q    <= dir_d;
      done_q   <= done_d;
      turn_q   <= turn_d;
      cnt_q    <= cnt_d;
      st_q     <= st_d;
      active_q <= on_in;
      mode_q   <= mode_in;
    end
  end

  // Output stage trails the accumulator by one cycle so turn lines up with the extremum.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      signal_out      <= '0;
      dir_out         <= 1'b0;
      turn_out        <= 1'b0;
      done_out        <= 1'b0;
      sweep_count_out <= '0;
    end else if (!on_in) begin
      signal_out      <= '0;
      dir_out         <= 1'b0;
      turn_out        <= 1'b0;
      done_out        <= 1'b0;
      sweep_count_out <= '0;
    end else begin
      signal_out      <= acc_q[AccW-1 -: SIGNAL_OUT_SIZE+2];
      dir_out         <= dir_q;
      turn_out        <= turn_q;
      done_out        <= done_q;
      sweep_count_out <= cnt_q;
    end
  end

endmodule
